mac_operand_sequencer: RTL and testbench

- Upstream feeder for the PIM multiply-accumulate stage.
- On a start command it reads LEN operand pairs from two local SRAM banks (A and B) and streams them into the MAC.
- It drives the MAC's clear/next controls aligned to the MAC's 2-stage operand/multiply pipeline.
- It captures the final 59-bit partial sum and offers it on a valid/ready result port.

---
 rtl/mac_operand_sequencer.sv | 131 +++++++++++++
 tb/tb_mac_operand_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// Fetches LEN operand pairs from the A/B banks, feeds the MAC with clear/next aligned to its pipeline,
// and presents the final partial sum; the result is held until res_ready, and new starts are ignored while busy.
module mac_operand_sequencer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11,
    parameter int A_W    = 26,
    parameter int B_W    = 29,
    parameter int PSUM_W = 59
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [A_W-1:0]    a_rdata,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [B_W-1:0]    b_rdata,
    output logic [A_W-1:0]    mac_a,
    output logic [B_W-1:0]    mac_b,
    output logic              mac_clear,
    output logic              mac_next,
    input  logic [PSUM_W-1:0] mac_psum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PSUM_W-1:0] res_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_a_q, base_b_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [2:0]          vld_q;
    logic [PSUM_W-1:0]   res_data_q, res_data_d;
    logic                issue;
    logic                capture;
    logic                accept;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        issue      = 1'b0;
        capture    = 1'b0;
        res_data_d = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                idx_d   = '0;
                state_d = (len_q != '0) ? S_ISSUE : S_DRAIN;
            end
            S_ISSUE: begin
                issue = 1'b1;
                idx_d = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Empty valid pipe means the last mac_next was the previous cycle,
                // so its accumulate is now visible on mac_psum.
                if (vld_q == 3'b000) begin
                    capture    = 1'b1;
                    res_data_d = mac_psum;
                    state_d    = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            base_a_q   <= '0;
            base_b_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            vld_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vld_q      <= {vld_q[1:0], issue};
            res_data_q <= res_data_d;
            if (accept) begin
                base_a_q <= base_a;
                base_b_q <= base_b;
                len_q    <= len;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign a_rd_en   = issue;
    assign b_rd_en   = issue;
    assign a_addr    = issue ? (base_a_q + idx_q[ADDR_W-1:0]) : '0;
    assign b_addr    = issue ? (base_b_q + idx_q[ADDR_W-1:0]) : '0;
    // Operands are forced to zero outside valid beats to keep the multiplier quiet.
    assign mac_a     = vld_q[0] ? a_rdata : '0;
    assign mac_b     = vld_q[0] ? b_rdata : '0;
    assign mac_clear = (state_q == S_CLR);
    assign mac_next  = vld_q[2];
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench: SRAM and 2-stage MAC models around the sequencer, table-driven jobs plus reset-abort sequence.
module tb_mac_operand_sequencer;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;
    localparam int A_W    = 26;
    localparam int B_W    = 29;
    localparam int PSUM_W = 59;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_a = '0;
    logic [ADDR_W-1:0] base_b = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [A_W-1:0]    a_rdata = '0;
    logic [B_W-1:0]    b_rdata = '0;
    logic [A_W-1:0]    mac_a;
    logic [B_W-1:0]    mac_b;
    logic              mac_clear, mac_next;
    logic [PSUM_W-1:0] mac_psum = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [PSUM_W-1:0] res_data;

    int n_chk = 0;
    int n_fail = 0;

    logic [A_W-1:0]    mem_a [0:1023];
    logic [B_W-1:0]    mem_b [0:1023];
    logic [A_W-1:0]    s1_a = '0;
    logic [B_W-1:0]    s1_b = '0;
    logic [PSUM_W-1:0] prod = '0;

    mac_operand_sequencer #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .A_W(A_W), .B_W(B_W), .PSUM_W(PSUM_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_a(base_a), .base_b(base_b), .len(len), .busy(busy),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear), .mac_next(mac_next),
        .mac_psum(mac_psum), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // SRAM banks with one-cycle read latency
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= mem_a[a_addr];
        if (b_rd_en) b_rdata <= mem_b[b_addr];
    end

    // MAC: operand register, product register, then accumulate on mac_next
    always @(posedge clk) begin
        if (!reset_n) begin
            s1_a     <= '0;
            s1_b     <= '0;
            prod     <= '0;
            mac_psum <= '0;
        end else begin
            s1_a <= mac_a;
            s1_b <= mac_b;
            prod <= PSUM_W'(s1_a) * PSUM_W'(s1_b);
            if (mac_clear)     mac_psum <= '0;
            else if (mac_next) mac_psum <= mac_psum + prod;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int base_a;
        int base_b;
        int rdy_delay;
        int s2a;
        int s2b;
        longint exp_res;
        int exp_vcyc;
    } vec_t;

    vec_t vecs [7];

    task automatic run_job(input vec_t v);
        int clr_n = 0, clr_c = -1, rd_n = 0, rd_bad = 0;
        int nx_n = 0, nx_first = -1, nx_last = -1, ovl = 0;
        int vfirst = -1, hold_bad = 0, done_c = -1, extra_v = 0;
        logic [PSUM_W-1:0] held = '0;
        @(negedge clk);
        base_a    = ADDR_W'(v.base_a);
        base_b    = ADDR_W'(v.base_b);
        len       = LEN_W'(v.len);
        start     = 1'b1;
        res_ready = (v.rdy_delay == 0);
        for (int n = 1; n <= v.len + 60; n++) begin
            @(negedge clk);
            start = (n == v.s2a) || (n == v.s2b);
            if (start) len = LEN_W'(1);
            if (n == 1) chk("busy_after_start", busy, 1);
            if (mac_clear) begin
                clr_n++;
                if (clr_c < 0) clr_c = n;
            end
            if (a_rd_en != b_rd_en) rd_bad++;
            if (a_rd_en) begin
                if (a_addr != ADDR_W'(v.base_a + rd_n) || b_addr != ADDR_W'(v.base_b + rd_n)) rd_bad++;
                rd_n++;
            end
            if (mac_next) begin
                nx_n++;
                if (nx_first < 0) nx_first = n;
                nx_last = n;
                if (mac_clear) ovl++;
            end
            if (res_valid) begin
                if (vfirst < 0) begin
                    vfirst = n;
                    held   = res_data;
                end else if (done_c < 0 && res_data != held) begin
                    hold_bad++;
                end
                if (done_c >= 0) extra_v++;
                if (done_c < 0 && !res_ready && n >= vfirst + v.rdy_delay) res_ready = 1'b1;
                if (done_c < 0 && res_ready) done_c = n;
            end else if (vfirst >= 0 && done_c < 0) begin
                hold_bad++;
            end
            if (done_c >= 0 && n == done_c + 1) begin
                chk("busy_low_after_handshake", busy, 0);
                res_ready = (v.rdy_delay == 0);
            end
            if (done_c >= 0 && n >= done_c + 4) break;
        end
        chk("handshake_seen", done_c >= 0, 1);
        chk("clear_count", clr_n, 1);
        chk("clear_cycle", clr_c, 1);
        chk("read_count", rd_n, v.len);
        chk("read_addr_errors", rd_bad, 0);
        chk("next_count", nx_n, v.len);
        chk("next_first", nx_first, (v.len > 0) ? 5 : -1);
        chk("next_last", nx_last, (v.len > 0) ? v.len + 4 : -1);
        chk("clear_next_overlap", ovl, 0);
        chk("valid_cycle", vfirst, v.exp_vcyc);
        chk("res_data", held, v.exp_res);
        chk("res_hold_errors", hold_bad, 0);
        chk("extra_valid", extra_v, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = A_W'(i + 1);
            mem_b[i] = B_W'(i + 5);
        end
        mem_a[100] = 3;  mem_a[101] = 3;
        mem_b[100] = 4;  mem_b[101] = 4;
        mem_a[1022] = 2; mem_a[1023] = 3; mem_a[0] = 1;
        mem_b[1023] = 8;
        mem_a[200] = 7;  mem_b[200] = 9;
        for (int i = 0; i < 10; i++) begin
            mem_a[300 + i] = A_W'(i + 1);
            mem_b[300 + i] = 2;
        end

        //            len base_a base_b rdy s2a s2b  res  vcyc
        vecs[0] = '{  4,    0,     0,   0,  0,  0,   70,  10};
        vecs[1] = '{  0,    0,     0,   0,  0,  0,    0,   3};
        vecs[2] = '{  2,  100,   100,   5,  0,  0,   24,   8};
        vecs[3] = '{  4,    0,     0,   0,  3,  7,   70,  10};
        vecs[4] = '{  3, 1022,  1023,   0,  0,  0,   37,   9};
        vecs[5] = '{ 10,  300,   300,   0,  0,  0,  110,  16};
        vecs[6] = '{  1,  200,   200,   0,  0,  0,   63,   7};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("reset_mac_ctl", {mac_clear, mac_next}, 0);
        chk("reset_res", {res_valid, res_data}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int k = 0; k < 6; k++) begin
            run_job(vecs[k]);
        end

        // Abort a len=8 job with reset in cycle 4, then run a fresh job.
        @(negedge clk);
        base_a = '0; base_b = '0; len = LEN_W'(8); start = 1'b1; res_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 4) begin
                chk("midop_reading", a_rd_en, 1);
                reset_n = 1'b0;
            end
        end
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("abort_addr", {a_addr, b_addr}, 0);
        chk("abort_operands", {mac_a, mac_b}, 0);
        chk("abort_mac_ctl", {mac_clear, mac_next}, 0);
        chk("abort_res", {res_valid, res_data}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_mac_next_stays_low", mac_next, 0);
        run_job(vecs[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
